// File: rtl/tdm_demux.sv
// ============================================================================
// Module   : tdm_demux
// Brief    : TDM slot demultiplexer; reassembles framed slot beats into a
//            registered parallel word and monitors frame alignment.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tdm_demux #(
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2,
    parameter int WIDTH    = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [WIDTH-1:0]          in_data,
    input  logic                      frame_sync,
    output logic [CHANNELS*WIDTH-1:0] out,
    output logic                      frame_valid,
    output logic [SEL_W-1:0]          select,
    output logic                      locked,
    output logic                      sync_err
);

    typedef enum logic [0:0] {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam logic [SEL_W-1:0] c_LAST_SLOT = SEL_W'(CHANNELS - 1);
    localparam logic [SEL_W-1:0] c_SLOT0     = '0;
    localparam logic [SEL_W-1:0] c_SLOT1     = SEL_W'(1);

    state_t                      r_state;
    state_t                      w_state;
    logic [SEL_W-1:0]            r_sel;
    logic [SEL_W-1:0]            w_sel;
    logic [CHANNELS*WIDTH-1:0]   r_shadow;
    logic [CHANNELS*WIDTH-1:0]   w_shadow;
    logic [CHANNELS*WIDTH-1:0]   r_out;
    logic [CHANNELS*WIDTH-1:0]   w_out;
    logic                        r_fv;
    logic                        w_fv;
    logic                        r_err;
    logic                        w_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= HUNT;
            r_sel    <= '0;
            r_shadow <= '0;
            r_out    <= '0;
            r_fv     <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_sel    <= w_sel;
            r_shadow <= w_shadow;
            r_out    <= w_out;
            r_fv     <= w_fv;
            r_err    <= w_err;
        end
    end

    always_comb begin
        w_state  = r_state;
        w_sel    = r_sel;
        w_shadow = r_shadow;
        w_out    = r_out;
        w_fv     = 1'b0;
        w_err    = 1'b0;
        if (in_valid) begin
            case (r_state)
                HUNT: begin
                    if (frame_sync) begin
                        w_shadow[0 +: WIDTH] = in_data;
                        w_sel                = c_SLOT1;
                        w_state              = LOCKED;
                    end
                end
                LOCKED: begin
                    if (frame_sync) begin
                        // A sync mid-frame abandons the partial frame and restarts at slot 0.
                        w_err                = (r_sel != c_SLOT0);
                        w_shadow[0 +: WIDTH] = in_data;
                        w_sel                = c_SLOT1;
                    end else if (r_sel == c_SLOT0) begin
                        w_err   = 1'b1;
                        w_state = HUNT;
                    end else begin
                        w_shadow[int'(r_sel)*WIDTH +: WIDTH] = in_data;
                        w_sel = r_sel + c_SLOT1;
                        if (r_sel == c_LAST_SLOT) begin
                            // Final lane bypasses the shadow so it is not taken stale.
                            w_out = r_shadow;
                            w_out[(CHANNELS-1)*WIDTH +: WIDTH] = in_data;
                            w_fv  = 1'b1;
                        end
                    end
                end
                default: w_state = HUNT;
            endcase
        end
    end

    assign out         = r_out;
    assign frame_valid = r_fv;
    assign select      = r_sel;
    assign locked      = (r_state == LOCKED);
    assign sync_err    = r_err;

endmodule

`default_nettype wire

// File: tb/tb_tdm_demux.sv
// ============================================================================
// Module   : tb_tdm_demux
// Brief    : Directed self-checking bench for tdm_demux (4 slots x 1 bit).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tdm_demux;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [0:0] in_data;
    logic       frame_sync;
    logic [3:0] out;
    logic       frame_valid;
    logic [1:0] select;
    logic       locked;
    logic       sync_err;

    int n_tests;
    int n_fail;

    tdm_demux #(.CHANNELS(4), .SEL_W(2), .WIDTH(1)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .frame_sync  (frame_sync),
        .out         (out),
        .frame_valid (frame_valid),
        .select      (select),
        .locked      (locked),
        .sync_err    (sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample #1 after the capturing edge.
    task automatic step(input logic v, input logic d, input logic s);
        @(negedge clk);
        in_valid   = v;
        in_data    = d;
        frame_sync = s;
        @(posedge clk);
        #1;
    endtask

    // Full frame, sync on slot 0; d[k] is lane k.
    task automatic send_frame(input logic [3:0] d, input string tag);
        for (int k = 0; k < 4; k++) begin
            step(1'b1, d[k], k == 0);
            chk({tag, "_sel"}, 32'(select), 32'((k + 1) % 4));
            chk({tag, "_fv"}, 32'(frame_valid), (k == 3) ? 32'd1 : 32'd0);
            chk({tag, "_err"}, 32'(sync_err), 32'd0);
        end
        chk({tag, "_out"}, 32'(out), 32'(d));
        chk({tag, "_lock"}, 32'(locked), 32'd1);
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_data    = 1'b0;
        frame_sync = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out", 32'(out), 32'd0);
        chk("rst_fv", 32'(frame_valid), 32'd0);
        chk("rst_err", 32'(sync_err), 32'd0);
        chk("rst_sel", 32'(select), 32'd0);
        chk("rst_lock", 32'(locked), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Non-sync beats in HUNT are discarded.
        step(1'b1, 1'b1, 1'b0);
        chk("hunt_lock", 32'(locked), 32'd0);
        chk("hunt_sel", 32'(select), 32'd0);

        // Basic decode: lanes 1,0,1,1 -> 4'b1101
        send_frame(4'b1101, "basic");
        step(1'b0, 1'b0, 1'b0);
        chk("basic_fv_drop", 32'(frame_valid), 32'd0);
        chk("basic_hold", 32'(out), 32'hD);

        // Gapped stream: 3 idle cycles between beats 2 and 3, sync ignored when idle
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        for (int g = 0; g < 3; g++) begin
            step(1'b0, 1'b1, g == 1);
            chk("gap_sel", 32'(select), 32'd2);
            chk("gap_fv", 32'(frame_valid), 32'd0);
        end
        step(1'b1, 1'b1, 1'b0);
        chk("gap_fv3", 32'(frame_valid), 32'd0);
        step(1'b1, 1'b1, 1'b0);
        chk("gap_fv4", 32'(frame_valid), 32'd1);
        chk("gap_out", 32'(out), 32'hD);
        step(1'b0, 1'b0, 1'b0);
        chk("gap_once", 32'(frame_valid), 32'd0);

        // Back-to-back frames
        send_frame(4'b0001, "b2b_a");
        send_frame(4'b1000, "b2b_b");

        // Early sync: two beats, then sync(1), then 1,1,0 -> 4'b0111
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        chk("early_err", 32'(sync_err), 32'd1);
        chk("early_fv", 32'(frame_valid), 32'd0);
        chk("early_sel", 32'(select), 32'd1);
        chk("early_out", 32'(out), 32'h8);
        chk("early_lock", 32'(locked), 32'd1);
        step(1'b1, 1'b1, 1'b0);
        chk("early_err_drop", 32'(sync_err), 32'd0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk("early_fv2", 32'(frame_valid), 32'd1);
        chk("early_out2", 32'(out), 32'h7);
        chk("early_lock2", 32'(locked), 32'd1);

        // Missing sync: complete frame then a slot-0 beat without sync
        send_frame(4'b0110, "miss_pre");
        step(1'b1, 1'b1, 1'b0);
        chk("miss_err", 32'(sync_err), 32'd1);
        chk("miss_lock", 32'(locked), 32'd0);
        chk("miss_sel", 32'(select), 32'd0);
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1'b1, 1'b0);
            chk("miss_fv", 32'(frame_valid), 32'd0);
            chk("miss_lock_hold", 32'(locked), 32'd0);
        end
        chk("miss_out", 32'(out), 32'h6);
        send_frame(4'b1010, "relock");

        // Reset mid-frame: two slots, then async reset between edges
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        chk("arst_out", 32'(out), 32'd0);
        chk("arst_sel", 32'(select), 32'd0);
        chk("arst_lock", 32'(locked), 32'd0);
        chk("arst_fv", 32'(frame_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        // Remaining beats of the interrupted frame must not complete anything.
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk("arst_discard", 32'(frame_valid), 32'd0);
        send_frame(4'b0101, "post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/tdm_demux.md
Name: tdm_demux

Overview:
- Receive-side counterpart of the 4:1 channel multiplexer.
- Takes a time-division-multiplexed stream where one channel slot is presented per valid beat, with slot 0 marked by a frame sync.
- Reassembles the slots into a registered parallel word, one lane per channel, and emits a one-cycle strobe per complete frame.
- Sits between the serial link and the parallel channel consumers; detects and recovers from frame misalignment.

Parameters:
- CHANNELS, 4, number of TDM slots per frame; must be a power of 2, minimum 2.
- SEL_W, 2, slot index width; equals log2(CHANNELS).
- WIDTH, 1, data bits carried per slot.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  current in_data/frame_sync are a valid slot beat.
- in_data  input  WIDTH  slot payload.
- frame_sync  input  1  qualified by in_valid; marks the beat as slot 0.
- out  output  CHANNELS*WIDTH  last complete frame; lane k at bits [k*WIDTH +: WIDTH].
- frame_valid  output  1  one-cycle pulse when out is updated.
- select  output  SEL_W  slot index the next valid beat will be written to.
- locked  output  1  high while in LOCKED state.
- sync_err  output  1  one-cycle pulse on a detected misalignment.

Behaviour:
- Reset (async, any time incl. mid-frame) forces:
  - out=0, frame_valid=0, sync_err=0, select=0, locked=0;
  - shadow lanes=0;
  - state=HUNT.
- Two states: HUNT, LOCKED. Internal shadow register holds CHANNELS lanes. select is the slot counter.
- Cycles with in_valid=0: no state, counter or shadow change. frame_valid and sync_err return to 0. frame_sync is ignored.
- HUNT:
  - Valid beat with frame_sync=0: discarded, stay in HUNT.
  - Valid beat with frame_sync=1: shadow[0]<=in_data, select<=1, go to LOCKED.
- LOCKED, valid beat with frame_sync=0 and select!=0:
  - shadow[select]<=in_data, select<=select+1 (wraps modulo CHANNELS).
- LOCKED, valid beat at select=CHANNELS-1 with frame_sync=0:
  - Next edge: out<=shadow with lane CHANNELS-1 replaced by in_data (same-cycle bypass; final lane is not read from stale shadow).
  - frame_valid=1 for exactly that cycle; select<=0.
  - Latency: out/frame_valid valid one clock after the final slot beat.
- LOCKED, valid beat with frame_sync=1 and select=0:
  - Normal frame start: shadow[0]<=in_data, select<=1.
- LOCKED, valid beat with frame_sync=1 and select!=0 (early sync):
  - sync_err pulse; partial frame discarded, out unchanged.
  - Beat taken as new slot 0: shadow[0]<=in_data, select<=1, remain LOCKED.
- LOCKED, valid beat with frame_sync=0 and select=0 (missing sync):
  - sync_err pulse; beat discarded; select stays 0; go to HUNT; locked drops next cycle.
- Shadow lanes not rewritten in a frame keep stale values, but out is only updated on a complete frame, so stale values never reach out.
- frame_valid and sync_err are never high in the same cycle.
- out holds its value between frame_valid pulses.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset mid-frame:
  - Stimulus: assert rst asynchronously after 2 of 4 slots, release, then send a full frame.
  - Required: outputs 0 immediately on rst; frame discarded before rst; following full frame decoded normally.
- Basic decode:
  - Stimulus: rst, then valid beats 1,0,1,1 with sync on the first beat.
  - Required: locked=1 after beat 1; frame_valid=1 one cycle after beat 4; out=4'b1101 (lane0=1, lane1=0, lane2=1, lane3=1); select sequence 1,2,3,0.
- Gapped stream:
  - Stimulus: same frame with in_valid=0 for 3 cycles between beats 2 and 3.
  - Required: same out=4'b1101; select holds at 2 during the gap; exactly one frame_valid pulse.
- Back-to-back frames:
  - Stimulus: 0001-pattern frame (beats 1,0,0,0) immediately followed by beats 0,0,0,1, sync on each slot 0.
  - Required: out=4'b0001, then out=4'b1000 four beats later; two frame_valid pulses, no sync_err.
- Early sync:
  - Stimulus: after 2 beats, a sync beat (data 1), then 3 more beats 1,1,0.
  - Required: sync_err pulse after the third beat; no frame_valid for the partial frame; then out=4'b0111, locked stays 1.
- Missing sync:
  - Stimulus: complete frame, then a valid beat at slot 0 with frame_sync=0.
  - Required: sync_err pulse; locked=0; subsequent non-sync beats ignored (no frame_valid) until a sync beat relocks.
